// File: rtl/in256_out1536_flex.sv
// in256_out1536_flex: packs 256-bit stream beats into 1536-bit words of
// 1..6 lanes (pack_num; 0 or 7 act as 6), zero-filling unused upper lanes.
// Ports: clk, rst_n (async, active-low), pack_num[2:0],
//   s_axis_tdata[255:0]/tvalid/tready (in), m_axis_tdata[1535:0]/tvalid/tready (out).
// Optional macro IN256_OUT1536_TLAST_EN adds s_axis_tlast/m_axis_tlast;
// a tlast beat closes the word early.
module in256_out1536_flex #(
    localparam int IN_W  = 256,
    localparam int LANES = 6,
    localparam int OUT_W = IN_W * LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       pack_num,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
`ifdef IN256_OUT1536_TLAST_EN
    input  logic             s_axis_tlast,
    output logic             m_axis_tlast,
`endif
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       num_q, num_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [2:0]       eff_num;
    logic [2:0]       num_cur;
    logic             at_last;
    logic             tlast_in;
    logic             accept;
    logic             close;
    logic [OUT_W-1:0] word_w;

`ifdef IN256_OUT1536_TLAST_EN
    logic last_q, last_d;
    assign tlast_in = s_axis_tlast;
`else
    assign tlast_in = 1'b0;
`endif

    always_comb begin
        eff_num = (pack_num == 3'd0 || pack_num == 3'd7) ? 3'd6 : pack_num;
        // At a word boundary the live pack_num governs; mid-word the latched one.
        num_cur = (cnt_q == 3'd0) ? eff_num : num_q;
        at_last = (cnt_q == num_cur - 3'd1);
`ifdef IN256_OUT1536_TLAST_EN
        s_axis_tready = ~valid_q | m_axis_tready;
`else
        s_axis_tready = ~at_last | ~valid_q | m_axis_tready;
`endif
        accept = s_axis_tvalid & s_axis_tready;
        close  = accept & (at_last | tlast_in);

        // Lanes above cnt in asm_q are always zero, so the partial word
        // plus the current beat is already correctly zero-filled.
        word_w = asm_q;
        for (int k = 0; k < LANES; k++) begin
            if (cnt_q == 3'(k)) begin
                word_w[k*IN_W +: IN_W] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        num_d   = num_q;
        asm_d   = asm_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef IN256_OUT1536_TLAST_EN
        last_d  = last_q;
`endif
        if (valid_q & m_axis_tready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (cnt_q == 3'd0) begin
                num_d = eff_num;
            end
            if (close) begin
                data_d  = word_w;
                valid_d = 1'b1;
                cnt_d   = 3'd0;
                asm_d   = '0;
`ifdef IN256_OUT1536_TLAST_EN
                last_d  = tlast_in;
`endif
            end else begin
                cnt_d = cnt_q + 3'd1;
                asm_d = word_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            num_q   <= 3'd6;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef IN256_OUT1536_TLAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef IN256_OUT1536_TLAST_EN
            last_q  <= last_d;
`endif
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
`ifdef IN256_OUT1536_TLAST_EN
    assign m_axis_tlast  = last_q;
`endif

endmodule

// File: tb/tb_in256_out1536_flex.sv
// Testbench for in256_out1536_flex: directed table of per-cycle vectors
// plus hand-written reset and tlast sequences.
module tb_in256_out1536_flex;

`ifdef IN256_OUT1536_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    pack_num;
    logic [255:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [1535:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
`ifdef IN256_OUT1536_TLAST_EN
    logic          tl_drv;
    logic          m_tlast;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    in256_out1536_flex dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pack_num      (pack_num),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
`ifdef IN256_OUT1536_TLAST_EN
        .s_axis_tlast  (tl_drv),
        .m_axis_tlast  (m_tlast),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct {
        logic [2:0]  pn;
        logic        v;
        logic [7:0]  b;
        logic        mr;
        logic        rdy;
        logic        mv;
        logic [47:0] lanes;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [2:0] pn, logic v, logic [7:0] b,
                                logic mr, logic rdy, logic mv,
                                logic [47:0] lanes);
        vec_t r;
        r.pn = pn; r.v = v; r.b = b; r.mr = mr;
        r.rdy = rdy; r.mv = mv; r.lanes = lanes;
        tbl.push_back(r);
    endfunction

    task automatic chk1(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_data(string nm, logic [47:0] lanes);
        logic [255:0] exp;
        for (int k = 0; k < 6; k++) begin
            exp = {32{lanes[8*k +: 8]}};
            n_cmp++;
            if (m_axis_tdata[256*k +: 256] !== exp) begin
                n_bad++;
                $display("FAIL %s_lane%0d: got %h expected %h", nm, k,
                         m_axis_tdata[256*k +: 256], exp);
            end
        end
    endtask

    // Drive one cycle: inputs now, ready checked before the edge,
    // outputs checked 1 time unit after the edge.
    task automatic step(vec_t r, string nm);
        pack_num      = r.pn;
        s_axis_tvalid = r.v;
        s_axis_tdata  = {32{r.b}};
        m_axis_tready = r.mr;
        #3;
        chk1({nm, "_rdy"}, s_axis_tready, r.rdy);
        @(posedge clk);
        #1;
        chk1({nm, "_mv"}, m_axis_tvalid, r.mv);
        if (r.mv) chk_data(nm, r.lanes);
    endtask

    task automatic beat(logic [2:0] pn, logic [7:0] b, logic mr, logic rdy,
                        logic mv, logic [47:0] lanes, string nm);
        vec_t r;
        r.pn = pn; r.v = 1'b1; r.b = b; r.mr = mr;
        r.rdy = rdy; r.mv = mv; r.lanes = lanes;
        step(r, nm);
    endtask

    initial begin
        rst_n         = 1'b0;
        pack_num      = 3'd6;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
`ifdef IN256_OUT1536_TLAST_EN
        tl_drv        = 1'b0;
`endif

        // pack_num 6, full word, valid for one cycle
        for (int i = 1; i <= 5; i++) add(6, 1, 8'(i), 1, 1, 0, 0);
        add(6, 1, 8'h06, 1, 1, 1, 48'h060504030201);
        add(6, 0, 8'h00, 1, 1, 0, 0);
        // pack_num 4, two words, upper lanes zero
        for (int i = 1; i <= 3; i++) add(4, 1, 8'(i), 1, 1, 0, 0);
        add(4, 1, 8'h04, 1, 1, 1, 48'h000004030201);
        for (int i = 5; i <= 7; i++) add(4, 1, 8'(i), 1, 1, 0, 0);
        add(4, 1, 8'h08, 1, 1, 1, 48'h000008070605);
        add(4, 0, 8'h00, 1, 1, 0, 0);
        // downstream stall with output full
        for (int i = 1; i <= 5; i++) add(6, 1, 8'(i), 1, 1, 0, 0);
        add(6, 1, 8'h06, 1, 1, 1, 48'h060504030201);
`ifndef IN256_OUT1536_TLAST_EN
        for (int i = 7; i <= 11; i++)
            add(6, 1, 8'(i), 0, 1, 1, 48'h060504030201);
        for (int i = 0; i < 5; i++)
            add(6, 1, 8'h0c, 0, 0, 1, 48'h060504030201);
        add(6, 1, 8'h0c, 1, 1, 1, 48'h0c0b0a090807);
`else
        for (int i = 0; i < 3; i++)
            add(6, 1, 8'h07, 0, 0, 1, 48'h060504030201);
        add(6, 1, 8'h07, 1, 1, 0, 0);
        for (int i = 8; i <= 11; i++) add(6, 1, 8'(i), 1, 1, 0, 0);
        add(6, 1, 8'h0c, 1, 1, 1, 48'h0c0b0a090807);
`endif
        add(6, 0, 8'h00, 1, 1, 0, 0);
        // pack_num 6 -> 2 mid-word
        for (int i = 1; i <= 3; i++) add(6, 1, 8'(i), 1, 1, 0, 0);
        add(2, 1, 8'h04, 1, 1, 0, 0);
        add(2, 1, 8'h05, 1, 1, 0, 0);
        add(2, 1, 8'h06, 1, 1, 1, 48'h060504030201);
        add(2, 1, 8'h07, 1, 1, 0, 0);
        add(2, 1, 8'h08, 1, 1, 1, 48'h000000000807);
        add(2, 1, 8'h09, 1, 1, 0, 0);
        add(2, 1, 8'h0a, 1, 1, 1, 48'h000000000a09);
        add(2, 0, 8'h00, 1, 1, 0, 0);
        // pack_num 1: word per cycle, stall, simultaneous replace
        add(1, 1, 8'h21, 1, 1, 1, 48'h21);
        add(1, 1, 8'h22, 1, 1, 1, 48'h22);
        add(1, 1, 8'h23, 1, 1, 1, 48'h23);
        add(1, 1, 8'h24, 0, 0, 1, 48'h23);
        add(1, 1, 8'h24, 1, 1, 1, 48'h24);
        add(1, 0, 8'h00, 1, 1, 0, 0);
        // pack_num 7 and 0 behave as 6
        for (int i = 1; i <= 5; i++) add(7, 1, 8'(8'h30 + i), 1, 1, 0, 0);
        add(7, 1, 8'h36, 1, 1, 1, 48'h363534333231);
        add(7, 0, 8'h00, 1, 1, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 8'(8'h50 + i), 1, 1, 0, 0);
        add(0, 1, 8'h56, 1, 1, 1, 48'h565554535251);
        add(0, 0, 8'h00, 1, 1, 0, 0);

        // reset state
        #2;
        chk1("rst_mv", m_axis_tvalid, 1'b0);
        chk1("rst_rdy", s_axis_tready, 1'b1);
        chk_data("rst_data", 48'h0);
`ifdef IN256_OUT1536_TLAST_EN
        chk1("rst_tlast", m_tlast, 1'b0);
`endif
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

        // async reset with a pending output and a partial word
        for (int i = 1; i <= 5; i++)
            beat(6, 8'(i), 1, 1, 0, 0, $sformatf("ra%0d", i));
        beat(6, 8'h06, 1, 1, 1, 48'h060504030201, "ra6");
        for (int i = 7; i <= 9; i++)
            beat(6, 8'(i), 0, !TL, 1, 48'h060504030201,
                 $sformatf("ra%0d", i));
        s_axis_tdata = {32{8'hee}};
        rst_n = 1'b0;
        #1;
        chk1("rs_mv", m_axis_tvalid, 1'b0);
        chk1("rs_rdy", s_axis_tready, 1'b1);
        chk_data("rs_data", 48'h0);
        @(posedge clk);
        #1;
        chk1("rs_hold_mv", m_axis_tvalid, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++)
            beat(6, 8'(8'h40 + i), 1, 1, 0, 0, $sformatf("rp%0d", i));
        beat(6, 8'h46, 1, 1, 1, 48'h464544434241, "rp6");

`ifdef IN256_OUT1536_TLAST_EN
        // tlast closes the word early
        beat(6, 8'h01, 1, 1, 0, 0, "tl1");
        beat(6, 8'h02, 1, 1, 0, 0, "tl2");
        tl_drv = 1'b1;
        beat(6, 8'h03, 1, 1, 1, 48'h000000030201, "tl3");
        chk1("tl3_last", m_tlast, 1'b1);
        tl_drv = 1'b0;
        for (int i = 4; i <= 8; i++)
            beat(6, 8'(i), 1, 1, 0, 0, $sformatf("tl%0d", i));
        beat(6, 8'h09, 1, 1, 1, 48'h090807060504, "tl9");
        chk1("tl9_last", m_tlast, 1'b0);
`endif
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk1("end_mv", m_axis_tvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
